// File: rtl/battle_pkg.sv
// rtl/battle_pkg.sv - shared cell/phase encodings and button bit positions for battle_board_ctrl
package battle_pkg;

  localparam int CELL_W = 2;

  typedef enum logic [CELL_W-1:0] {
    WATER = 2'b00,
    SHIP  = 2'b01,
    HIT   = 2'b10,
    MISS  = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    PLACE = 3'd2,
    FIRE  = 3'd3,
    DONE  = 3'd4
  } phase_t;

  localparam int BTN_START = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;
  localparam int BTN_PLACE = 5;
  localparam int BTN_FIRE  = 6;
  localparam int BTN_N     = 7;

endpackage

// File: rtl/battle_board_ctrl_btn_edge.sv
// rtl/battle_board_ctrl_btn_edge.sv - vector rising-edge detector; history resets high so held buttons stay silent
module btn_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_lvl,
  output logic [W-1:0] o_evt
);

  logic [W-1:0] r_prev;

  always_ff @(posedge clk) begin
    if (!rst) r_prev <= '1;
    else      r_prev <= i_lvl;
  end

  assign o_evt = i_lvl & ~r_prev;

endmodule

// File: rtl/battle_board_ctrl.sv
// rtl/battle_board_ctrl.sv - Battleship board controller: clear/place/fire/done FSM, cursor and shot resolution.
// Define BATTLE_CURSOR_WRAP_EN for toroidal cursor moves; otherwise the cursor saturates at the edges.
module battle_board_ctrl
  import battle_pkg::*;
#(
  parameter int BOARD_N    = 5,
  parameter int MAX_SHIPS  = 7,
  parameter int SHOT_LIMIT = 15,
  parameter int IDX_W      = $clog2(BOARD_N),
  parameter int SHIP_W     = $clog2(MAX_SHIPS + 1),
  parameter int SHOT_W     = $clog2(SHOT_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              move_up,
  input  logic              move_down,
  input  logic              move_left,
  input  logic              move_right,
  input  logic              place_req,
  input  logic              fire_req,
  input  logic [SHIP_W-1:0] num_ships,
  input  logic [IDX_W-1:0]  rd_i,
  input  logic [IDX_W-1:0]  rd_j,
  output logic [CELL_W-1:0] rd_cell,
  output logic [IDX_W-1:0]  cur_i,
  output logic [IDX_W-1:0]  cur_j,
  output logic [2:0]        phase,
  output logic [SHIP_W-1:0] ships_placed,
  output logic [SHIP_W-1:0] ships_left,
  output logic [SHOT_W-1:0] shots,
  output logic              shot_valid,
  output logic              shot_hit,
  output logic              done,
  output logic              victory
);

  localparam int CELLS  = BOARD_N * BOARD_N;
  localparam int ADDR_W = $clog2(CELLS);
  localparam logic [IDX_W-1:0]  MAX_IDX   = IDX_W'(BOARD_N - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [SHIP_W-1:0] MAX_TGT   = SHIP_W'(MAX_SHIPS);
  localparam logic [SHOT_W-1:0] LAST_SHOT = SHOT_W'(SHOT_LIMIT - 1);

  cell_t              r_board [CELLS];
  phase_t             r_state;
  phase_t             w_state_nxt;
  logic [IDX_W-1:0]   r_cur_i, r_cur_j, w_cur_i_nxt, w_cur_j_nxt;
  logic [ADDR_W-1:0]  r_clr_addr;
  logic [SHIP_W-1:0]  r_target, r_ships_placed, r_ships_left, w_left_nxt;
  logic [SHOT_W-1:0]  r_shots;
  logic               r_shot_valid, r_shot_hit, r_victory;
  logic [BTN_N-1:0]   w_lvl, w_evt;
  logic [ADDR_W-1:0]  w_cur_addr, w_rd_addr;
  cell_t              w_cur_cell;
  logic               w_moves_en, w_enter_clear, w_place_ok, w_fire_ok, w_fire_hit;

  assign w_lvl = {fire_req, place_req, move_right, move_left, move_down, move_up, start};

  btn_edge #(.W(BTN_N)) u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .i_lvl (w_lvl),
    .o_evt (w_evt)
  );

  assign w_cur_addr = ADDR_W'(r_cur_i) * ADDR_W'(BOARD_N) + ADDR_W'(r_cur_j);
  assign w_rd_addr  = ADDR_W'(rd_i) * ADDR_W'(BOARD_N) + ADDR_W'(rd_j);
  assign w_cur_cell = r_board[w_cur_addr];

  always_comb begin
    rd_cell = WATER;
    if (rd_i <= MAX_IDX && rd_j <= MAX_IDX) rd_cell = r_board[w_rd_addr];
  end

  assign w_enter_clear = w_evt[BTN_START] && (r_state == IDLE || r_state == DONE);
  assign w_place_ok    = (r_state == PLACE) && w_evt[BTN_PLACE] && (w_cur_cell == WATER)
                         && (r_ships_placed != r_target);
  assign w_fire_ok     = (r_state == FIRE) && w_evt[BTN_FIRE]
                         && (w_cur_cell == WATER || w_cur_cell == SHIP);
  assign w_fire_hit    = (w_cur_cell == SHIP);
  assign w_left_nxt    = w_fire_hit ? r_ships_left - SHIP_W'(1) : r_ships_left;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Game-over is decided on the resolving shot itself so no extra shot can sneak in.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_evt[BTN_START]) w_state_nxt = CLEAR;
      CLEAR: if (r_clr_addr == LAST_ADDR) w_state_nxt = PLACE;
      PLACE: if (r_ships_placed == r_target) w_state_nxt = FIRE;
      FIRE:  if (w_fire_ok && (w_left_nxt == '0 || r_shots == LAST_SHOT)) w_state_nxt = DONE;
      DONE:  if (w_evt[BTN_START]) w_state_nxt = CLEAR;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    phase      = r_state;
    done       = (r_state == DONE);
    w_moves_en = (r_state == PLACE) || (r_state == FIRE);
  end

  always_comb begin
    w_cur_i_nxt = r_cur_i;
    w_cur_j_nxt = r_cur_j;
    if (w_moves_en) begin
      if (w_evt[BTN_UP]) begin
        if (r_cur_i != '0) w_cur_i_nxt = r_cur_i - 1'b1;
`ifdef BATTLE_CURSOR_WRAP_EN
        else               w_cur_i_nxt = MAX_IDX;
`endif
      end else if (w_evt[BTN_DOWN]) begin
        if (r_cur_i != MAX_IDX) w_cur_i_nxt = r_cur_i + 1'b1;
`ifdef BATTLE_CURSOR_WRAP_EN
        else                    w_cur_i_nxt = '0;
`endif
      end else if (w_evt[BTN_LEFT]) begin
        if (r_cur_j != '0) w_cur_j_nxt = r_cur_j - 1'b1;
`ifdef BATTLE_CURSOR_WRAP_EN
        else               w_cur_j_nxt = MAX_IDX;
`endif
      end else if (w_evt[BTN_RIGHT]) begin
        if (r_cur_j != MAX_IDX) w_cur_j_nxt = r_cur_j + 1'b1;
`ifdef BATTLE_CURSOR_WRAP_EN
        else                    w_cur_j_nxt = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < CELLS; k++) r_board[k] <= WATER;
      r_cur_i        <= '0;
      r_cur_j        <= '0;
      r_clr_addr     <= '0;
      r_target       <= '0;
      r_ships_placed <= '0;
      r_ships_left   <= '0;
      r_shots        <= '0;
      r_shot_valid   <= 1'b0;
      r_shot_hit     <= 1'b0;
      r_victory      <= 1'b0;
    end else begin
      r_shot_valid <= 1'b0;
      r_cur_i      <= w_cur_i_nxt;
      r_cur_j      <= w_cur_j_nxt;
      if (w_enter_clear) begin
        r_cur_i        <= '0;
        r_cur_j        <= '0;
        r_clr_addr     <= '0;
        r_ships_placed <= '0;
        r_ships_left   <= '0;
        r_shots        <= '0;
        r_shot_hit     <= 1'b0;
        r_victory      <= 1'b0;
      end
      if (r_state == CLEAR) begin
        r_board[r_clr_addr] <= WATER;
        r_clr_addr          <= r_clr_addr + 1'b1;
        if (r_clr_addr == LAST_ADDR) begin
          if (num_ships == '0)          r_target <= SHIP_W'(1);
          else if (num_ships > MAX_TGT) r_target <= MAX_TGT;
          else                          r_target <= num_ships;
        end
      end
      if (w_place_ok) begin
        r_board[w_cur_addr] <= SHIP;
        r_ships_placed      <= r_ships_placed + 1'b1;
        r_ships_left        <= r_ships_left + 1'b1;
      end
      if (w_fire_ok) begin
        r_board[w_cur_addr] <= w_fire_hit ? HIT : MISS;
        r_shots             <= r_shots + 1'b1;
        r_ships_left        <= w_left_nxt;
        r_shot_valid        <= 1'b1;
        r_shot_hit          <= w_fire_hit;
        r_victory           <= (w_left_nxt == '0);
      end
    end
  end

  assign cur_i        = r_cur_i;
  assign cur_j        = r_cur_j;
  assign ships_placed = r_ships_placed;
  assign ships_left   = r_ships_left;
  assign shots        = r_shots;
  assign shot_valid   = r_shot_valid;
  assign shot_hit     = r_shot_hit;
  assign victory      = r_victory;

endmodule

// File: tb/tb_battle_board_ctrl.sv
// tb/tb_battle_board_ctrl.sv - directed scoreboard bench for battle_board_ctrl (BOARD_N=5, SHOT_LIMIT=3)
module tb_battle_board_ctrl;

  localparam int N      = 5;
  localparam int IDX_W  = 3;
  localparam int SHIP_W = 3;
  localparam int SHOT_W = 2;

  logic              clk, rst, start;
  logic              move_up, move_down, move_left, move_right, place_req, fire_req;
  logic [SHIP_W-1:0] num_ships;
  logic [IDX_W-1:0]  rd_i, rd_j;
  logic [1:0]        rd_cell;
  logic [IDX_W-1:0]  cur_i, cur_j;
  logic [2:0]        phase;
  logic [SHIP_W-1:0] ships_placed, ships_left;
  logic [SHOT_W-1:0] shots;
  logic              shot_valid, shot_hit, done, victory;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic exp_q[$];
  int   exp_i, exp_j;

  battle_board_ctrl #(.BOARD_N(N), .MAX_SHIPS(7), .SHOT_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .place_req(place_req), .fire_req(fire_req), .num_ships(num_ships),
    .rd_i(rd_i), .rd_j(rd_j), .rd_cell(rd_cell), .cur_i(cur_i), .cur_j(cur_j),
    .phase(phase), .ships_placed(ships_placed), .ships_left(ships_left), .shots(shots),
    .shot_valid(shot_valid), .shot_hit(shot_hit), .done(done), .victory(victory)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 0=start 1=up 2=down 3=left 4=right 5=place 6=fire
  task automatic press(input int b);
    case (b)
      0: start = 1'b1;      1: move_up = 1'b1;    2: move_down = 1'b1;
      3: move_left = 1'b1;  4: move_right = 1'b1; 5: place_req = 1'b1;
      default: fire_req = 1'b1;
    endcase
    tick();
    {start, move_up, move_down, move_left, move_right, place_req, fire_req} = '0;
    tick();
  endtask

  task automatic check_cell(input int i, input int j, input logic [1:0] exp, input string tag);
    rd_i = IDX_W'(i);
    rd_j = IDX_W'(j);
    tick();
    chk(tag, rd_cell, exp);
  endtask

  // Scoreboard: every shot_valid pulse must match the oldest expected outcome.
  always @(negedge clk) begin
    if (rst && shot_valid) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_pulse: observed pulse expected none (shot_hit=%0d)", shot_hit);
      end
      if (exp_q.size() != 0) chk("shot_hit", shot_hit, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b0; start = 1'b1; move_right = 1'b1;
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; place_req = 1'b0; fire_req = 1'b0;
    num_ships = 3'd2; rd_i = '0; rd_j = '0;
    repeat (3) tick();
    chk("rst_phase", phase, 0);
    chk("rst_cur_i", cur_i, 0);
    chk("rst_cur_j", cur_j, 0);
    chk("rst_shots", shots, 0);
    chk("rst_placed", ships_placed, 0);
    chk("rst_done", done, 0);
    chk("rst_victory", victory, 0);
    chk("rst_cell", rd_cell, 0);

    rst = 1'b1;
    tick(); tick();
    chk("held_start_no_event", phase, 0);
    start = 1'b0; move_right = 1'b0;
    tick();
    press(4);
    chk("idle_move_ignored", cur_j, 0);

    start = 1'b1;
    tick();
    chk("enter_clear", phase, 1);
    start = 1'b0;
    repeat (24) tick();
    chk("clear_cycle25", phase, 1);
    tick();
    chk("clear_to_place", phase, 2);

    press(4); chk("move_right", cur_j, 1);
    press(3); chk("move_left", cur_j, 0);
    press(5);
    chk("place1_count", ships_placed, 1);
    check_cell(0, 0, 2'b01, "place1_cell");
    press(5); chk("place_dup_ignored", ships_placed, 1);
    press(2); chk("move_down", cur_i, 1);
    press(5);
    chk("place2_count", ships_placed, 2);
    chk("place2_left", ships_left, 2);
    chk("to_fire", phase, 3);

    press(4);
    exp_q.push_back(1'b0);
    fire_req = 1'b1;
    tick();
    chk("miss_pulse", shot_valid, 1);
    fire_req = 1'b0;
    tick();
    chk("miss_pulse_one_cycle", shot_valid, 0);
    chk("miss_shots", shots, 1);
    check_cell(1, 1, 2'b11, "miss_cell");
    fire_req = 1'b1;
    tick();
    chk("refire_no_pulse", shot_valid, 0);
    fire_req = 1'b0;
    tick();
    chk("refire_shots", shots, 1);

    press(1); press(3);
    exp_q.push_back(1'b1);
    press(6);
    chk("hit1_left", ships_left, 1);
    chk("hit1_shots", shots, 2);
    press(2);
    exp_q.push_back(1'b1);
    press(6);
    chk("hit2_left", ships_left, 0);
    chk("last_shot_shots", shots, 3);
    chk("win_done", done, 1);
    chk("win_victory", victory, 1);
    chk("win_phase", phase, 4);
    press(4); chk("done_move_ignored", cur_j, 0);
    press(6); chk("done_fire_ignored", shots, 3);
    check_cell(1, 0, 2'b10, "hit_cell");

    num_ships = 3'd1;
    press(0);
    chk("restart_done_clr", done, 0);
    chk("restart_shots_clr", shots, 0);
    chk("restart_victory_clr", victory, 0);
    repeat (24) tick();
    chk("game2_place", phase, 2);
    repeat (4) press(2);
    repeat (4) press(4);
    chk("game2_cur_i", cur_i, 4);
    chk("game2_cur_j", cur_j, 4);
    press(5);
    chk("game2_fire", phase, 3);
    for (int k = 0; k < 3; k++) begin
      press(3);
      exp_q.push_back(1'b0);
      press(6);
    end
    chk("loss_shots", shots, 3);
    chk("loss_done", done, 1);
    chk("loss_victory", victory, 0);
    chk("loss_left", ships_left, 1);

    num_ships = 3'd0;
    press(0);
    repeat (24) tick();
    chk("game3_place", phase, 2);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check_cell(i, j, 2'b00, $sformatf("swept_%0d_%0d", i, j));

    repeat (4) press(4);
    chk("edge_col4", cur_j, 4);
    press(4);
`ifdef BATTLE_CURSOR_WRAP_EN
    exp_j = 0; exp_i = 4;
`else
    exp_j = 4; exp_i = 0;
`endif
    chk("edge_right", cur_j, exp_j);
    press(1);
    chk("edge_up", cur_i, exp_i);
    press(5);
    chk("clamp_target_one", phase, 3);

    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
